phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
- Traffic-light phase generator; the upstream producer of the cur_phase/seven_num interface that the display controller consumes.
- Steps through phases 0..4 from a 1 Hz tick derived from the 25 MHz clk.
- Drives a per-phase seconds countdown on seven_num.
- Latches pedestrian requests; a cycle with no request skips the walk phases.
- set forces and holds phase 0.

Parameters:
- TICK_DIV, 25000000: clk cycles per 1 s tick; legal range >= 2.
- D0, 5: phase 0 (walk) duration in seconds; legal range 1..9.
- D1, 3: phase 1 (walk flashing) duration in seconds; legal range 1..9.
- D2, 6: phase 2 (walk off) duration in seconds; legal range 1..9.
- D3, 2: phase 3 duration in seconds; legal range 1..9.
- D4, 4: phase 4 duration in seconds; legal range 1..9.

Ports:
- clk  input  1  25 MHz clock.
- rst  input  1  reset, asynchronous, active-low; rst=0 resets all state immediately.
- set  input  1  level, synchronous to clk; high = clear to phase 0 and hold.
- ped_req  input  1  pedestrian request; any high cycle registers a request.
- cur_phase  output  3  current phase, 0..4; values 5..7 are never driven.
- seven_num  output  4  seconds remaining in the current phase, 1..Dn.
- ped_pending  output  1  a pedestrian request is latched.
- tick  output  1  one-cycle pulse on each 1 s boundary.

Behaviour:
- Reset (rst=0, async): cur_phase=0, seven_num=D0, ped_pending=0, tick=0, prescaler=0. First tick comes TICK_DIV cycles after rst deasserts.
- Prescaler, ceil(log2 TICK_DIV) bits:
  - counts 0..TICK_DIV-1; the cycle it equals TICK_DIV-1 raises tick for exactly 1 cycle, and the prescaler wraps to 0 on that edge.
  - Tick period is exactly TICK_DIV cycles.
- Countdown: on a tick cycle,
  - if seven_num>1: seven_num decrements by 1 at the next edge.
  - if seven_num==1: phase advances and seven_num loads D(next) at the same edge.
  - Each phase therefore lasts exactly Dn ticks.
  - seven_num never shows 0 and never exceeds 9.
- Phase FSM: states P0..P4, encoded 0..4. Transitions happen only on a tick with seven_num==1:
  - P0->P1, P1->P2, P2->P3, P3->P4.
  - P4->P0 if (ped_pending | ped_req) in that cycle, else P4->P2 (walk skipped).
- ped_pending:
  - Set at the edge after any cycle with ped_req=1.
  - Cleared at the edge that enters P0.
  - If entering P0 and ped_req=1 in the same cycle, the clear wins: ped_pending=0.
- set=1, sampled each edge; priority above tick and all transitions:
  - next edge: cur_phase=0, seven_num=D0, prescaler=0, tick=0.
  - ped_pending is cleared.
  - For as long as set stays high, the state is held and no ticks are issued.
  - After set falls, the first tick comes TICK_DIV cycles later.
- Simultaneous set and tick: set wins, and no advance or decrement happens.
- rst asserted mid-phase: outputs take their reset values immediately, with no clock edge required. Operation restarts from P0 when rst deasserts.
- Implementation:
  - Outputs are registered; no combinational path from any input to any output.
  - Latency from a tick cycle to the cur_phase/seven_num update is 1 edge.
  - tick is combinational from the prescaler register only.
- Out-of-range parameters (Dn=0 or >9, TICK_DIV<2) are rejected at elaboration.

Test Plan:
- Reset: hold rst=0 and toggle clk; also drop rst mid-phase 3 between clock edges -> cur_phase=0, seven_num=5, ped_pending=0, tick=0, all immediately.
- Full cycle with walk: TICK_DIV=4, D=(3,2,2,1,2), one-cycle ped_req pulse after reset -> ped_pending=1 next edge, then:
  - seven_num 3,2,1 in P0, each held 4 cycles; ped_pending clears at the edge that enters P0 (after P4).
  - then P1:2,1; P2:2,1; P3:1; P4:2,1; then P0 with seven_num=3.
  - Phase changes occur exactly on edges following tick.
- Walk skip: same parameters, no ped_req -> after P4 reaches seven_num=1 and ticks, cur_phase=2, seven_num=2; P0/P1 never appear.
- Late request: ped_req=1 only in the P4 final tick cycle, with ped_pending=0 -> next state P0, seven_num=D0, ped_pending=0 (clear wins).
- Set hold: assert set for 10 cycles during P3 -> next edge cur_phase=0, seven_num=D0, no tick during the hold; after release, tick exactly 4 cycles later and seven_num decrements to D0-1.
- Set/tick collision: set rises in the tick cycle where P2 has seven_num==1 -> result P0/D0, never P3.

Source files
------------

// File: rtl/phase_sequencer.sv
// Traffic-light phase sequencer.
// Generates phases 0..4 paced by a 1 s tick, counts down the seconds left in
// each phase for the seven-segment display, and latches pedestrian requests.
// A cycle with no request goes from phase 4 straight back to phase 2, which
// skips the walk phases.
module phase_sequencer #(
    parameter int unsigned TICK_DIV = 25000000,
    parameter int unsigned D0       = 5,
    parameter int unsigned D1       = 3,
    parameter int unsigned D2       = 6,
    parameter int unsigned D3       = 2,
    parameter int unsigned D4       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       set,
    input  logic       ped_req,
    output logic [2:0] cur_phase,
    output logic [3:0] seven_num,
    output logic       ped_pending,
    output logic       tick
);

    // Phase durations must fit a single display digit and never be zero.
    // The prescaler needs at least two states to produce a single-cycle tick.
    if (TICK_DIV < 2) begin : g_bad_tick_div
        $error("phase_sequencer: TICK_DIV must be >= 2");
    end
    if (D0 < 1 || D0 > 9 || D1 < 1 || D1 > 9 || D2 < 1 || D2 > 9 ||
        D3 < 1 || D3 > 9 || D4 < 1 || D4 > 9) begin : g_bad_duration
        $error("phase_sequencer: phase durations must be in 1..9");
    end

    localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [3:0] D0_V = 4'(D0);
    localparam logic [3:0] D1_V = 4'(D1);
    localparam logic [3:0] D2_V = 4'(D2);
    localparam logic [3:0] D3_V = 4'(D3);
    localparam logic [3:0] D4_V = 4'(D4);

    typedef enum logic [2:0] {
        P0 = 3'd0,
        P1 = 3'd1,
        P2 = 3'd2,
        P3 = 3'd3,
        P4 = 3'd4
    } phase_t;

    phase_t        phase_q;
    phase_t        next_phase;
    logic [PW-1:0] prescaler;
    logic          last_second;
    logic          enter_p0;
    logic [3:0]    next_duration;

    // The tick depends only on the prescaler register, so it is glitch-free
    // with respect to the inputs.
    assign tick = (prescaler == PRESC_LAST);

    assign last_second = tick && (seven_num == 4'd1);
    assign enter_p0    = last_second && (next_phase == P0);
    assign cur_phase   = phase_q;

    // Phase following the current one; a request seen in the final cycle of
    // phase 4 still counts, so the walk is not missed by one cycle.
    always_comb begin
        next_phase = P0;
        unique case (phase_q)
            P0:      next_phase = P1;
            P1:      next_phase = P2;
            P2:      next_phase = P3;
            P3:      next_phase = P4;
            P4:      next_phase = (ped_pending || ped_req) ? P0 : P2;
            default: next_phase = P0;
        endcase
    end

    // Seconds to load when entering the next phase.
    always_comb begin
        next_duration = D0_V;
        unique case (next_phase)
            P0:      next_duration = D0_V;
            P1:      next_duration = D1_V;
            P2:      next_duration = D2_V;
            P3:      next_duration = D3_V;
            P4:      next_duration = D4_V;
            default: next_duration = D0_V;
        endcase
    end

    // Prescaler, phase FSM, countdown and request latch; set overrides
    // everything except the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescaler   <= '0;
            phase_q     <= P0;
            seven_num   <= D0_V;
            ped_pending <= 1'b0;
        end else if (set) begin
            prescaler   <= '0;
            phase_q     <= P0;
            seven_num   <= D0_V;
            ped_pending <= 1'b0;
        end else begin
            if (tick) begin
                prescaler <= '0;
            end else begin
                prescaler <= prescaler + PW'(1);
            end

            if (last_second) begin
                phase_q   <= next_phase;
                seven_num <= next_duration;
            end else if (tick) begin
                seven_num <= seven_num - 4'd1;
            end

            if (enter_p0) begin
                ped_pending <= 1'b0;
            end else if (ped_req) begin
                ped_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed testbench for phase_sequencer with a 4-cycle tick and durations
// (3,2,2,1,2); a second default-parameter instance checks the reset digit.
module tb_phase_sequencer;

    logic       clk;
    logic       rst;
    logic       set;
    logic       ped_req;
    logic [2:0] cur_phase;
    logic [3:0] seven_num;
    logic       ped_pending;
    logic       tick;

    logic [2:0] d_phase;
    logic [3:0] d_num;
    logic       d_ped;
    logic       d_tick;

    int assertions = 0;
    int failures   = 0;

    phase_sequencer #(
        .TICK_DIV(4), .D0(3), .D1(2), .D2(2), .D3(1), .D4(2)
    ) dut (
        .clk(clk), .rst(rst), .set(set), .ped_req(ped_req),
        .cur_phase(cur_phase), .seven_num(seven_num),
        .ped_pending(ped_pending), .tick(tick)
    );

    phase_sequencer dut_def (
        .clk(clk), .rst(rst), .set(set), .ped_req(ped_req),
        .cur_phase(d_phase), .seven_num(d_num),
        .ped_pending(d_ped), .tick(d_tick)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Counts one comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs, then returns 1 time unit after the edge.
    task automatic applyStimulus(input bit req, input bit s);
        ped_req = req;
        set     = s;
        @(posedge clk);
        #1;
        ped_req = 1'b0;
        set     = 1'b0;
    endtask

    // Checks one second (4 cycles) of the current phase starting at cycle
    // `first`; inject=1 pulses ped_req and inject=2 raises set in the tick cycle.
    task automatic run_second(input int ph, input int num, input int ped,
                              input int first, input int inject);
        for (int i = first; i < 4; i++) begin
            checkOutput("cur_phase", int'(cur_phase), ph);
            checkOutput("seven_num", int'(seven_num), num);
            checkOutput("ped_pending", int'(ped_pending), ped);
            checkOutput("tick", int'(tick), (i == 3) ? 1 : 0);
            if (i == 3 && inject == 1) begin
                applyStimulus(1'b1, 1'b0);
            end else if (i == 3 && inject == 2) begin
                applyStimulus(1'b0, 1'b1);
            end else begin
                applyStimulus(1'b0, 1'b0);
            end
        end
    endtask

    task automatic check_reset_values(input string where);
        checkOutput({where, " cur_phase"}, int'(cur_phase), 0);
        checkOutput({where, " seven_num"}, int'(seven_num), 3);
        checkOutput({where, " ped_pending"}, int'(ped_pending), 0);
        checkOutput({where, " tick"}, int'(tick), 0);
        checkOutput({where, " def cur_phase"}, int'(d_phase), 0);
        checkOutput({where, " def seven_num"}, int'(d_num), 5);
        checkOutput({where, " def ped_pending"}, int'(d_ped), 0);
        checkOutput({where, " def tick"}, int'(d_tick), 0);
    endtask

    initial begin
        rst     = 1'b0;
        set     = 1'b0;
        ped_req = 1'b0;

        // Reset held while the clock runs.
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst = 1'b1;

        // Full cycle with walk: request pulse right after reset.
        check_reset_values("release");
        applyStimulus(1'b1, 1'b0);
        run_second(0, 3, 1, 1, 0);
        run_second(0, 2, 1, 0, 0);
        run_second(0, 1, 1, 0, 0);
        run_second(1, 2, 1, 0, 0);
        run_second(1, 1, 1, 0, 0);
        run_second(2, 2, 1, 0, 0);
        run_second(2, 1, 1, 0, 0);
        run_second(3, 1, 1, 0, 0);
        run_second(4, 2, 1, 0, 0);
        run_second(4, 1, 1, 0, 0);

        // Back in P0 with the request consumed; no request this time.
        run_second(0, 3, 0, 0, 0);
        run_second(0, 2, 0, 0, 0);
        run_second(0, 1, 0, 0, 0);
        run_second(1, 2, 0, 0, 0);
        run_second(1, 1, 0, 0, 0);
        run_second(2, 2, 0, 0, 0);
        run_second(2, 1, 0, 0, 0);
        run_second(3, 1, 0, 0, 0);
        run_second(4, 2, 0, 0, 0);
        run_second(4, 1, 0, 0, 0);

        // Walk skipped: P4 goes to P2; then a late request in the P4 tick cycle.
        run_second(2, 2, 0, 0, 0);
        run_second(2, 1, 0, 0, 0);
        run_second(3, 1, 0, 0, 0);
        run_second(4, 2, 0, 0, 0);
        run_second(4, 1, 0, 0, 1);

        // Late request enters P0 with the latch cleared.
        run_second(0, 3, 0, 0, 0);
        run_second(0, 2, 0, 0, 0);
        run_second(0, 1, 0, 0, 0);
        run_second(1, 2, 0, 0, 0);
        run_second(1, 1, 0, 0, 0);
        run_second(2, 2, 0, 0, 0);
        run_second(2, 1, 0, 0, 0);

        // Set held for 10 cycles during P3.
        checkOutput("p3 before set phase", int'(cur_phase), 3);
        applyStimulus(1'b0, 1'b0);
        checkOutput("p3 before set num", int'(seven_num), 1);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput("set hold phase", int'(cur_phase), 0);
            checkOutput("set hold num", int'(seven_num), 3);
            checkOutput("set hold tick", int'(tick), 0);
            checkOutput("set hold ped", int'(ped_pending), 0);
        end
        run_second(0, 3, 0, 0, 0);
        run_second(0, 2, 0, 0, 0);
        run_second(0, 1, 0, 0, 0);
        run_second(1, 2, 0, 0, 0);
        run_second(1, 1, 0, 0, 0);
        run_second(2, 2, 0, 0, 0);

        // Set coincides with the P2 final tick: must land in P0, not P3.
        run_second(2, 1, 0, 0, 2);
        checkOutput("collision phase", int'(cur_phase), 0);
        checkOutput("collision num", int'(seven_num), 3);
        checkOutput("collision tick", int'(tick), 0);
        run_second(0, 3, 0, 0, 0);
        run_second(0, 2, 0, 0, 0);
        run_second(0, 1, 0, 0, 0);
        run_second(1, 2, 0, 0, 0);
        run_second(1, 1, 0, 0, 0);
        run_second(2, 2, 0, 0, 0);
        run_second(2, 1, 0, 0, 0);

        // Mid-P3 asynchronous reset, with a latched request and tick high.
        checkOutput("p3 entry phase", int'(cur_phase), 3);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("pre-reset phase", int'(cur_phase), 3);
        checkOutput("pre-reset num", int'(seven_num), 1);
        checkOutput("pre-reset ped", int'(ped_pending), 1);
        checkOutput("pre-reset tick", int'(tick), 1);
        #2;
        rst = 1'b0;
        #1;
        check_reset_values("async reset");

        // Restart from P0 after release.
        @(posedge clk);
        #1;
        rst = 1'b1;
        run_second(0, 3, 0, 0, 0);
        checkOutput("restart num", int'(seven_num), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
